// File: rtl/team_06_i2s_stereo_rx.sv
// Stereo I2S master receiver: generates SCK/WS, deserialises DATA_W MSB-first bits per slot.
// Optional TEAM_06_I2S_MAG_EN: output is the saturated magnitude of the received word.
module team_06_i2s_stereo_rx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SLOT_W  = 32,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sd_in,
  output logic              sck_out,
  output logic              ws_out,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned K_W   = $clog2(SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(SLOT_W - 1);
  localparam logic [K_W-1:0]   K_DATA   = K_W'(DATA_W);

  logic [DIV_W-1:0]  r_div;
  logic [K_W-1:0]    r_k;
  logic              r_sck;
  logic              r_ws;
  logic [DATA_W-1:0] r_shift;
  logic              r_done;
  logic              r_done_right;
  logic [DATA_W-1:0] r_data;
  logic              r_right;
  logic              r_valid;
  logic              r_ovf;

  logic              w_tc;
  logic              w_rise;
  logic              w_fall;
  logic              w_cap;
  logic              w_word;
  logic              w_ovf_set;
  logic [DATA_W-1:0] w_word_fmt;

  assign w_tc   = enable && (r_div == DIV_LAST);
  assign w_rise = w_tc && !r_sck;
  assign w_fall = w_tc && r_sck;
  assign w_cap  = w_rise && (r_k != '0) && (r_k <= K_DATA);
  assign w_word = w_rise && (r_k == K_DATA);

  // Bit clock, slot counter, word select and shift register; all held idle while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_k     <= '0;
      r_sck   <= 1'b0;
      r_ws    <= 1'b0;
      r_shift <= '0;
    end else if (!enable) begin
      r_div   <= '0;
      r_k     <= '0;
      r_sck   <= 1'b0;
      r_ws    <= 1'b0;
      r_shift <= '0;
    end else begin
      r_div <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc)
        r_sck <= ~r_sck;
      if (w_rise)
        r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
      // k is 0 on a fall only right after the last rise of a slot wrapped it
      if (w_fall && (r_k == '0))
        r_ws <= ~r_ws;
      if (w_cap)
        r_shift <= {r_shift[DATA_W-2:0], sd_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_done_right <= 1'b0;
    end else begin
      r_done <= w_word;
      if (w_word)
        r_done_right <= r_ws;
    end
  end

`ifdef TEAM_06_I2S_MAG_EN
  localparam logic [DATA_W-1:0] W_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    w_word_fmt = r_shift;
    if (r_shift[DATA_W-1])
      w_word_fmt = (r_shift == W_MIN) ? ~W_MIN : (~r_shift + 1'b1);
  end
`else
  assign w_word_fmt = r_shift;
`endif

  assign w_ovf_set = r_done && r_valid && !sample_ready;

  // One-deep output register; a word arriving while the held one is stalled is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_right <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_done) begin
        if (!r_valid || sample_ready) begin
          r_data  <= w_word_fmt;
          r_right <= r_done_right;
          r_valid <= 1'b1;
        end
      end else if (sample_ready) begin
        r_valid <= 1'b0;
      end
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (clear_ovf)
        r_ovf <= 1'b0;
    end
  end

  assign sck_out      = r_sck;
  assign ws_out       = r_ws;
  assign sample_data  = r_data;
  assign sample_right = r_right;
  assign sample_valid = r_valid;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_team_06_i2s_stereo_rx.sv
// Directed bench for team_06_i2s_stereo_rx (DATA_W=8, SLOT_W=32, CLK_DIV=2); honours TEAM_06_I2S_MAG_EN.
module tb_team_06_i2s_stereo_rx;

`ifdef TEAM_06_I2S_MAG_EN
  localparam bit MAG = 1'b1;
`else
  localparam bit MAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sd_in = 1'b0;
  logic       sample_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       sck_out;
  logic       ws_out;
  logic [7:0] sample_data;
  logic       sample_right;
  logic       sample_valid;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int got_n = 0;
  int got_cyc = 0;
  int last_cyc = 0;
  int n_before = 0;
  logic [7:0] got_data = '0;
  logic       got_right = 1'b0;
  logic       seen_valid;

  team_06_i2s_stereo_rx #(
    .DATA_W(8),
    .SLOT_W(32),
    .CLK_DIV(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sd_in(sd_in),
    .sck_out(sck_out),
    .ws_out(ws_out),
    .sample_data(sample_data),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overflow(overflow),
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ex(input logic [7:0] raw, input logic [7:0] mag);
    return MAG ? mag : raw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One slot = 32 SCK periods = 128 clk; the rise of each 4-edge group lands on its 2nd edge.
  task automatic send_slot(input logic [7:0] w, input int drop_k, input int clr_k, input int rdy_k);
    for (int k = 0; k < 32; k++) begin
      if (k >= 1 && k <= 8) sd_in = w[8-k];
      else sd_in = ~k[0];
      for (int j = 0; j < 4; j++) begin
        if (j == 2 && k == clr_k) clear_ovf = 1'b1;
        if (j == 2 && k == rdy_k) sample_ready = 1'b1;
        if (sample_valid && sample_ready) begin
          got_n++;
          got_data  = sample_data;
          got_right = sample_right;
          last_cyc  = got_cyc;
          got_cyc   = cyc;
        end
        tick();
        clear_ovf = 1'b0;
        if (j == 1 && k == drop_k) begin
          enable = 1'b0;
          return;
        end
      end
    end
  endtask

  initial begin
    #12;
    chk("rst_sck", sck_out, 0);
    chk("rst_ws", ws_out, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_right", sample_right, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ovf", overflow, 0);

    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    tick();
    chk("sck_cyc1", sck_out, 0);
    tick();
    chk("sck_cyc2", sck_out, 1);
    repeat (125) tick();
    chk("ws_cyc127", ws_out, 0);
    tick();
    chk("ws_cyc128", ws_out, 1);

    // Stereo capture with ready held high
    do_reset();
    sample_ready = 1'b1;
    send_slot(8'h5A, -1, -1, -1);
    chk("st_l_n", got_n, 1);
    chk("st_l_data", got_data, ex(8'h5A, 8'h5A));
    chk("st_l_right", got_right, 0);
    send_slot(8'hA5, -1, -1, -1);
    chk("st_r_n", got_n, 2);
    chk("st_r_data", got_data, ex(8'hA5, 8'h5B));
    chk("st_r_right", got_right, 1);
    chk("st_spacing", got_cyc - last_cyc, 128);

    send_slot(8'hF6, -1, -1, -1);
    chk("mag_f6", got_data, ex(8'hF6, 8'h0A));
    chk("mag_f6_right", got_right, 0);
    send_slot(8'h80, -1, -1, -1);
    chk("mag_80", got_data, ex(8'h80, 8'h7F));
    chk("mag_80_right", got_right, 1);
    send_slot(8'h05, -1, -1, -1);
    chk("mag_05", got_data, ex(8'h05, 8'h05));
    chk("mag_n", got_n, 5);

    // Backpressure across two slots, then clear colliding with a new overflow
    sample_ready = 1'b0;
    send_slot(8'h3C, -1, -1, -1);
    chk("bp_valid", sample_valid, 1);
    chk("bp_data", sample_data, ex(8'h3C, 8'h3C));
    chk("bp_right", sample_right, 1);
    chk("bp_ovf0", overflow, 0);
    send_slot(8'h77, -1, -1, -1);
    chk("bp_hold_data", sample_data, ex(8'h3C, 8'h3C));
    chk("bp_hold_right", sample_right, 1);
    chk("bp_ovf1", overflow, 1);
    send_slot(8'h11, -1, 8, -1);
    chk("bp_clr_vs_set", overflow, 1);
    chk("bp_hold2", sample_data, ex(8'h3C, 8'h3C));
    sample_ready = 1'b1;
    n_before = got_n;
    send_slot(8'h42, -1, 20, -1);
    chk("bp_drain_n", got_n - n_before, 2);
    chk("bp_new_data", got_data, ex(8'h42, 8'h42));
    chk("bp_new_right", got_right, 0);
    chk("bp_ovf_cleared", overflow, 0);

    // Enable drop mid left slot
    send_slot(8'h66, -1, -1, -1);
    chk("en_pre_r", got_data, ex(8'h66, 8'h66));
    n_before = got_n;
    send_slot(8'hFF, 4, -1, -1);
    chk("en_pre_sck", sck_out, 1);
    tick();
    chk("en_off_sck", sck_out, 0);
    chk("en_off_ws", ws_out, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sample_valid || sck_out) seen_valid = 1'b1;
    end
    chk("en_off_idle", seen_valid, 0);
    chk("en_off_n", got_n, n_before);
    enable = 1'b1;
    send_slot(8'h9C, -1, -1, -1);
    chk("en_re_n", got_n - n_before, 1);
    chk("en_re_data", got_data, ex(8'h9C, 8'h64));
    chk("en_re_right", got_right, 0);

    // New word completing while held sample is accepted in the same cycle
    sample_ready = 1'b0;
    send_slot(8'hC3, -1, -1, -1);
    chk("sim_held", sample_data, ex(8'hC3, 8'h3D));
    n_before = got_n;
    send_slot(8'h2D, -1, -1, 8);
    chk("sim_n", got_n - n_before, 2);
    chk("sim_data", got_data, ex(8'h2D, 8'h2D));
    chk("sim_right", got_right, 0);
    chk("sim_ovf", overflow, 0);

    // Asynchronous reset mid slot with every output non-zero
    sample_ready = 1'b0;
    send_slot(8'hE1, -1, -1, -1);
    send_slot(8'h01, -1, -1, -1);
    tick();
    tick();
    #2;
    chk("pre_sck", sck_out, 1);
    chk("pre_ws", ws_out, 1);
    chk("pre_valid", sample_valid, 1);
    chk("pre_data", sample_data, ex(8'hE1, 8'h1F));
    chk("pre_right", sample_right, 1);
    chk("pre_ovf", overflow, 1);
    rst = 1'b1;
    #1;
    chk("ar_sck", sck_out, 0);
    chk("ar_ws", ws_out, 0);
    chk("ar_data", sample_data, 0);
    chk("ar_right", sample_right, 0);
    chk("ar_valid", sample_valid, 0);
    chk("ar_ovf", overflow, 0);
    #20;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
